// File: rtl/inv_skew_detect.sv
// Measures which tunable inverter (up/down) leads over a fixed window and
// pulses a one-cycle O_INVU/O_INVD step code; flags lock after repeated balance.
module inv_skew_detect #(
  parameter int WINDOW        = 64,
  parameter int CNT_W         = 7,
  parameter int DEADBAND      = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_COUNT    = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic INVU_OUT,
  input  logic INVD_OUT,
  output logic O_INVU,
  output logic O_INVD,
  output logic LOCKED,
  output logic BUSY
);

  localparam int TMAX = (WINDOW > SETTLE_CYCLES) ? WINDOW : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DECIDE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       u_sync, d_sync;
  logic             su, sd;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [CNT_W-1:0] up_cnt, dn_cnt, up_nxt, dn_nxt;
  logic [BW-1:0]    bal, bal_nxt;
  logic             o_u_nxt, o_d_nxt, lock_nxt;
  logic [CNT_W:0]   up_ext, dn_ext, db;
  logic             up_lead, dn_lead;

  // Two-flop synchronizers for the free-running inverter outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      u_sync <= 2'b00;
      d_sync <= 2'b00;
    end else begin
      u_sync <= {u_sync[0], INVU_OUT};
      d_sync <= {d_sync[0], INVD_OUT};
    end
  end

  assign su = u_sync[1];
  assign sd = d_sync[1];

  // Widened by one bit so adding the deadband cannot wrap
  assign up_ext  = {1'b0, up_cnt};
  assign dn_ext  = {1'b0, dn_cnt};
  assign db      = (CNT_W + 1)'(DEADBAND);
  assign up_lead = up_ext > (dn_ext + db);
  assign dn_lead = dn_ext > (up_ext + db);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      tmr    <= '0;
      up_cnt <= '0;
      dn_cnt <= '0;
      bal    <= '0;
      O_INVU <= 1'b0;
      O_INVD <= 1'b0;
      LOCKED <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      up_cnt <= up_nxt;
      dn_cnt <= dn_nxt;
      bal    <= bal_nxt;
      O_INVU <= o_u_nxt;
      O_INVD <= o_d_nxt;
      LOCKED <= lock_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    up_nxt    = up_cnt;
    dn_nxt    = dn_cnt;
    bal_nxt   = bal;
    o_u_nxt   = 1'b0;
    o_d_nxt   = 1'b0;
    lock_nxt  = LOCKED;
    if (!EN) begin
      state_nxt = IDLE;
      tmr_nxt   = '0;
      up_nxt    = '0;
      dn_nxt    = '0;
      bal_nxt   = '0;
      lock_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = SETTLE;
          tmr_nxt   = '0;
          up_nxt    = '0;
          dn_nxt    = '0;
        end
        SETTLE: begin
          if (tmr == TW'(SETTLE_CYCLES - 1)) begin
            state_nxt = MEASURE;
            tmr_nxt   = '0;
            up_nxt    = '0;
            dn_nxt    = '0;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        MEASURE: begin
          if (su && !sd)      up_nxt = up_cnt + 1'b1;
          else if (!su && sd) dn_nxt = dn_cnt + 1'b1;
          if (tmr == TW'(WINDOW - 1)) begin
            state_nxt = DECIDE;
            tmr_nxt   = '0;
          end else begin
            tmr_nxt = tmr + 1'b1;
          end
        end
        DECIDE: begin
          state_nxt = SETTLE;
          tmr_nxt   = '0;
          if (up_lead) begin
            o_u_nxt  = 1'b1;
            bal_nxt  = '0;
            lock_nxt = 1'b0;
          end else if (dn_lead) begin
            o_d_nxt  = 1'b1;
            bal_nxt  = '0;
            lock_nxt = 1'b0;
          end else begin
            if (bal != BW'(LOCK_COUNT)) bal_nxt = bal + 1'b1;
            lock_nxt = (bal_nxt == BW'(LOCK_COUNT));
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_inv_skew_detect.sv
// Bench for inv_skew_detect: back-to-back 73-cycle windows from a vector table,
// scoreboarded decisions, plus EN-drop and asynchronous-reset sequences.
module tb_inv_skew_detect;

  localparam int PERIOD = 73;
  localparam int M_UP = 0, M_DN = 1, M_TOG = 2, M_PULSE = 3;

  logic CLK, RST, EN, INVU_OUT, INVD_OUT;
  logic O_INVU, O_INVD, LOCKED, BUSY;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         mode;
    int         up_len;
    int         dn_len;
    logic [1:0] code;
    logic       lock;
  } vec_t;

  typedef struct {
    logic [1:0] code;
    logic       lock;
    int         id;
  } exp_t;

  vec_t vecs[17];
  exp_t sb[$];

  inv_skew_detect #(
    .WINDOW(64), .CNT_W(7), .DEADBAND(2), .SETTLE_CYCLES(8), .LOCK_COUNT(4)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .INVU_OUT(INVU_OUT), .INVD_OUT(INVD_OUT),
    .O_INVU(O_INVU), .O_INVD(O_INVD), .LOCKED(LOCKED), .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Raw inverter levels for window cycle c (c = 0 is the cycle after SETTLE entry)
  task automatic drive_inputs(input int mode, input int up_len, input int dn_len, input int c);
    case (mode)
      M_UP:    begin INVU_OUT = 1'b1; INVD_OUT = 1'b0; end
      M_DN:    begin INVU_OUT = 1'b0; INVD_OUT = 1'b1; end
      M_TOG:   begin INVU_OUT = c[0]; INVD_OUT = c[0]; end
      default: begin
        INVU_OUT = (c >= 20) && (c < 20 + up_len);
        INVD_OUT = (c >= 40) && (c < 40 + dn_len);
      end
    endcase
  endtask

  // Called #1 after the edge that enters SETTLE; returns #1 after the decision edge
  task automatic run_window(input int mode, input int up_len, input int dn_len,
                            input logic [1:0] code, input logic lock, input int id);
    exp_t e;
    int   stray;
    e.code = code;
    e.lock = lock;
    e.id   = id;
    sb.push_back(e);
    stray = 0;
    drive_inputs(mode, up_len, dn_len, 0);
    for (int c = 1; c <= PERIOD; c++) begin
      @(posedge CLK);
      #1;
      if (c < PERIOD) begin
        if (O_INVU || O_INVD) stray++;
        drive_inputs(mode, up_len, dn_len, c);
      end
    end
    check($sformatf("win%0d_no_stray_pulse", id), stray, 0);
    e = sb.pop_front();
    check($sformatf("win%0d_code", e.id), {O_INVU, O_INVD}, e.code);
    check($sformatf("win%0d_locked", e.id), LOCKED, e.lock);
  endtask

  initial begin
    int stray;

    vecs[0]  = '{M_UP,    0, 0, 2'b10, 1'b0};
    vecs[1]  = '{M_UP,    0, 0, 2'b10, 1'b0};
    vecs[2]  = '{M_TOG,   0, 0, 2'b00, 1'b0};
    vecs[3]  = '{M_PULSE, 2, 0, 2'b00, 1'b0};
    vecs[4]  = '{M_PULSE, 3, 0, 2'b10, 1'b0};
    vecs[5]  = '{M_PULSE, 0, 3, 2'b01, 1'b0};
    vecs[6]  = '{M_PULSE, 0, 2, 2'b00, 1'b0};
    vecs[7]  = '{M_TOG,   0, 0, 2'b00, 1'b0};
    vecs[8]  = '{M_PULSE, 3, 1, 2'b00, 1'b0};
    vecs[9]  = '{M_TOG,   0, 0, 2'b00, 1'b1};
    vecs[10] = '{M_TOG,   0, 0, 2'b00, 1'b1};
    vecs[11] = '{M_DN,    0, 0, 2'b01, 1'b0};
    vecs[12] = '{M_PULSE, 4, 1, 2'b10, 1'b0};
    vecs[13] = '{M_TOG,   0, 0, 2'b00, 1'b0};
    vecs[14] = '{M_TOG,   0, 0, 2'b00, 1'b0};
    vecs[15] = '{M_TOG,   0, 0, 2'b00, 1'b0};
    vecs[16] = '{M_TOG,   0, 0, 2'b00, 1'b1};

    RST = 1'b1; EN = 1'b0; INVU_OUT = 1'b0; INVD_OUT = 1'b0;
    #1;
    check("reset_o_invu", O_INVU, 1'b0);
    check("reset_o_invd", O_INVD, 1'b0);
    check("reset_locked", LOCKED, 1'b0);
    check("reset_busy",   BUSY,   1'b0);

    @(posedge CLK); @(posedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    check("idle_busy_en_low", BUSY, 1'b0);

    // Edge 0 reference: EN raised here, first sampled on the next edge
    EN = 1'b1;
    @(posedge CLK); #1;
    check("busy_after_en", BUSY, 1'b1);

    for (int i = 0; i < 17; i++)
      run_window(vecs[i].mode, vecs[i].up_len, vecs[i].dn_len, vecs[i].code, vecs[i].lock, i);

    // EN drop at MEASURE cycle 30 with the up side leading
    drive_inputs(M_UP, 0, 0, 0);
    for (int c = 1; c <= 38; c++) begin
      @(posedge CLK); #1;
    end
    check("en_drop_locked_before", LOCKED, 1'b1);
    EN = 1'b0;
    @(posedge CLK); #1;
    check("en_drop_busy",   BUSY,   1'b0);
    check("en_drop_locked", LOCKED, 1'b0);
    check("en_drop_code",   {O_INVU, O_INVD}, 2'b00);
    stray = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      if (O_INVU || O_INVD || BUSY) stray++;
    end
    check("en_low_quiet", stray, 0);
    EN = 1'b1;
    @(posedge CLK); #1;
    check("reenable_busy", BUSY, 1'b1);
    // A carried-over up count would turn this down-lead window into 10
    run_window(M_PULSE, 0, 3, 2'b01, 1'b0, 100);

    // Asynchronous reset mid-MEASURE, between clock edges
    drive_inputs(M_UP, 0, 0, 0);
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
    end
    check("pre_reset_busy", BUSY, 1'b1);
    #3 RST = 1'b1;
    #1;
    check("async_rst_busy",   BUSY,   1'b0);
    check("async_rst_code",   {O_INVU, O_INVD}, 2'b00);
    check("async_rst_locked", LOCKED, 1'b0);
    @(posedge CLK); @(posedge CLK);
    #4 RST = 1'b0;
    @(posedge CLK); #1;
    check("post_rst_busy", BUSY, 1'b1);
    run_window(M_UP, 0, 0, 2'b10, 1'b0, 200);

    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
